// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone command master.
// Optional feature macro used by the master: WB_CMD_MASTER_TIMEOUT_EN.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // IDLE: accepting a command; BUS: cyc/stb asserted; RESP: holding the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_mst_state_e;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] wdata;
    logic [WB_SEL_W-1:0] sel;
  } wb_cmd_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] rdata;
    logic                err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: 16-bit counter cleared by load, advanced while en is
// high, and flagging expiry on the cycle it holds LIMIT-1.
// Only instantiated when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt;

  // Clear on entry to the bus cycle, then count every cycle spent in it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic-cycle master: one command in, one single bus cycle,
// one response out. One transaction outstanding at a time.
// Optional macro WB_CMD_MASTER_TIMEOUT_EN adds a bus-cycle timeout of
// TIMEOUT_CYCLES; without it BUS waits indefinitely for ack/err.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge, and ready never
// depends combinationally on valid.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_wdata,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  wb_mst_state_e state, state_d;
  wb_cmd_t       cmd_q;
  wb_rsp_t       rsp_q, rsp_d;
  logic          cyc_q;
  logic          rsp_valid_q;
  logic          cmd_ready_q;
  logic          accept;
  logic          finish;
  logic          timeout;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  wb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .en     (state == BUS),
    .expired(timeout)
  );
`else
  // No timeout: the parameter is kept for interface compatibility only.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(16'(TIMEOUT_CYCLES));
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, handshake strobes and the response to capture.
  // err beats ack, and either beats the timeout.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    rsp_d   = '0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          finish    = 1'b1;
          rsp_d.err = 1'b1;
        end else if (wb_ack_i) begin
          finish      = 1'b1;
          rsp_d.rdata = cmd_q.we ? '0 : wb_dat_i;
        end else if (timeout) begin
          finish    = 1'b1;
          rsp_d.err = 1'b1;
        end
        if (finish) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: bus command, cycle control, response and cmd_ready.
  // cmd_ready is registered so it stays low during reset and rises one
  // clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == IDLE);
      if (accept) begin
        cmd_q <= '{we: cmd_we, adr: cmd_adr, wdata: cmd_wdata, sel: cmd_sel};
        cyc_q <= 1'b1;
      end
      if (finish) begin
        cyc_q       <= 1'b0;
        rsp_q       <= rsp_d;
        rsp_valid_q <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = cmd_q.we;
  assign wb_adr_o  = cmd_q.adr;
  assign wb_dat_o  = cmd_q.wdata;
  assign wb_sel_o  = cmd_q.sel;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed testbench for wb_cmd_master. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_wb_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int checks   = 0;
  int failures = 0;

  // Expected responses as {err, rdata}.
  logic [32:0] exp_q[$];
  logic [32:0] exp_rsp;

  wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_wdata(cmd_wdata),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  // Driver: present a command at a falling edge, let the next rising edge
  // take it, and return at the following falling edge (first BUS cycle).
  task automatic issue_cmd(input logic we, input logic [31:0] adr,
                           input logic [31:0] wdata, input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_wdata = wdata;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_wdata = '0;
    cmd_sel   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_wdata = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {cmd_ready, rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_data: got adr=%h dat=%h sel=%h rdata=%h err=%b expected all 0",
               wb_adr_o, wb_dat_o, wb_sel_o, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    rsp_ready = 1'b1;
    issue_cmd(1'b1, 32'h0000_0100, 32'hA5A5_0001, 4'hF);
    exp_q.push_back({1'b0, 32'h0});
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, rsp_valid} !== 5'b11100) begin
      failures++;
      $display("FAIL wr_bus_ctrl: got %b expected 11100", {wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, rsp_valid});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== {32'h0000_0100, 32'hA5A5_0001, 4'hF}) begin
      failures++;
      $display("FAIL wr_bus_data: got adr=%h dat=%h sel=%h expected 00000100 a5a50001 f",
               wb_adr_o, wb_dat_o, wb_sel_o);
    end
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    exp_rsp = exp_q.pop_front();
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b001) begin
      failures++;
      $display("FAIL wr_rsp_ctrl: got %b expected 001", {wb_cyc_o, wb_stb_o, rsp_valid});
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== exp_rsp) begin
      failures++;
      $display("FAIL wr_rsp_data: got %h expected %h", {rsp_err, rsp_rdata}, exp_rsp);
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {32'h0000_0100, 32'hA5A5_0001, 4'hF, 1'b1}) begin
      failures++;
      $display("FAIL wr_bus_hold: got adr=%h dat=%h sel=%h we=%b expected 00000100 a5a50001 f 1",
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL wr_return_idle: got %b expected 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read_wait3();
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 32'h0000_0104, 32'h1111_2222, 4'h3);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid} !== 4'b1100) begin
        failures++;
        $display("FAIL rd_wait_cyc[%0d]: got %b expected 1100", i, {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid});
      end
      if (i == 3) begin
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    exp_rsp = exp_q.pop_front();
    checks++;
    if ({wb_cyc_o, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, exp_rsp}) begin
      failures++;
      $display("FAIL rd_wait_rsp: got cyc=%b valid=%b rsp=%h expected 0 1 %h",
               wb_cyc_o, rsp_valid, {rsp_err, rsp_rdata}, exp_rsp);
    end
    checks++;
    if (wb_adr_o !== 32'h0000_0104) begin
      failures++;
      $display("FAIL rd_wait_adr: got %h expected 00000104", wb_adr_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rd_wait_idle: got %b expected 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_err_backpressure();
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    exp_q.push_back({1'b1, 32'h0});
    wb_err_i = 1'b1;
    wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    wb_err_i = 1'b0;
    exp_rsp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      // A stray ack while holding the response must be ignored.
      wb_ack_i = (i == 2);
      checks++;
      if ({rsp_valid, cmd_ready, wb_cyc_o, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, exp_rsp}) begin
        failures++;
        $display("FAIL err_hold[%0d]: got valid=%b ready=%b cyc=%b rsp=%h expected 1 0 0 %h",
                 i, rsp_valid, cmd_ready, wb_cyc_o, {rsp_err, rsp_rdata}, exp_rsp);
      end
      if (i < 4) @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, wb_cyc_o} !== 3'b010) begin
      failures++;
      $display("FAIL err_return_idle: got %b expected 010", {rsp_valid, cmd_ready, wb_cyc_o});
    end
  endtask

  task automatic test_ack_err_same();
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'h0000_0208, 32'h0, 4'hF);
    exp_q.push_back({1'b1, 32'h0});
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    exp_rsp = exp_q.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_rsp}) begin
      failures++;
      $display("FAIL ack_err_same: got valid=%b rsp=%h expected 1 %h", rsp_valid, {rsp_err, rsp_rdata}, exp_rsp);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'h0000_0300, 32'h0, 4'hF);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({wb_cyc_o, rsp_valid} !== 2'b10) begin
        failures++;
        $display("FAIL timeout_cyc[%0d]: got %b expected 10", i, {wb_cyc_o, rsp_valid});
      end
      @(negedge clk);
    end
    exp_rsp = exp_q.pop_front();
    checks++;
    if ({wb_cyc_o, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, exp_rsp}) begin
      failures++;
      $display("FAIL timeout_rsp: got cyc=%b valid=%b rsp=%h expected 0 1 %h",
               wb_cyc_o, rsp_valid, {rsp_err, rsp_rdata}, exp_rsp);
    end
    @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b110) begin
      failures++;
      $display("FAIL no_timeout_cyc: got %b expected 110", {wb_cyc_o, wb_stb_o, rsp_valid});
    end
    exp_q.push_back({1'b0, 32'h0000_5A5A});
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_5A5A;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    exp_rsp = exp_q.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_rsp}) begin
      failures++;
      $display("FAIL no_timeout_rsp: got valid=%b rsp=%h expected 1 %h", rsp_valid, {rsp_err, rsp_rdata}, exp_rsp);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_bus();
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got cyc=%b expected 1", wb_cyc_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_async: got %b expected 0000", {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, wb_cyc_o} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_release: got %b expected 10", {cmd_ready, wb_cyc_o});
    end
    issue_cmd(1'b0, 32'h0000_0408, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    checks++;
    if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h0000_0408}) begin
      failures++;
      $display("FAIL rst_mid_new_cmd: got cyc=%b adr=%h expected 1 00000408", wb_cyc_o, wb_adr_o);
    end
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BAD_F00D;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    exp_rsp = exp_q.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_rsp}) begin
      failures++;
      $display("FAIL rst_mid_new_rsp: got valid=%b rsp=%h expected 1 %h", rsp_valid, {rsp_err, rsp_rdata}, exp_rsp);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid_idle: got %b expected 01", {rsp_valid, cmd_ready});
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_err_backpressure();
    test_ack_err_same();
    test_timeout();
    test_reset_mid_bus();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
